// File: rtl/dbus_sram_slave.sv
// Data-bus responder: turns memory-stage requests into synchronous SRAM accesses,
// stalls reads until the fixed-latency data returns, and right-aligns the result.

module dbus_rd_lane #(
  parameter int LANE = 0
) (
  input  logic [63:0] word,
  input  logic [2:0]  off,
  output logic [7:0]  lane_byte
);
  logic [3:0] idx;
  assign idx       = 4'(LANE) + {1'b0, off};
  // Lanes pulled past the top of the word are zero-filled.
  assign lane_byte = idx[3] ? 8'h00 : word[{idx[2:0], 3'b000} +: 8];
endmodule

module dbus_sram_slave #(
  parameter int ADDR_W   = 16,
  parameter int SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dbus_ena,
  input  logic [7:0]        dbus_wea,
  input  logic [3:0]        dbus_rlen,
  input  logic [63:0]       dbus_addr,
  input  logic [63:0]       dbus_wdata,
  output logic [63:0]       dbus_rdata,
  output logic              dbus_stall,
  output logic              dbus_fault,
  output logic              sram_en,
  output logic [7:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [63:0]       sram_wdata,
  input  logic [63:0]       sram_rdata
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [2:0]  off_q, off_nxt;
  logic [63:0] rdata_q;
  logic        rd_ok, capture;
  logic [NUM_LANES-1:0][7:0] rd_shift;
  logic        unused_hi;

  assign sram_addr  = dbus_addr[ADDR_W+2:3];
  assign sram_wdata = dbus_wdata;
  assign dbus_rdata = rdata_q;
  assign unused_hi  = ^dbus_addr[63:ADDR_W+3];

  // A legal read is naturally aligned to its own length.
  always_comb begin
    rd_ok = 1'b0;
    case (dbus_rlen)
      4'd1:    rd_ok = 1'b1;
      4'd2:    rd_ok = ~dbus_addr[0];
      4'd4:    rd_ok = (dbus_addr[1:0] == 2'b00);
      4'd8:    rd_ok = (dbus_addr[2:0] == 3'b000);
      default: rd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    off_nxt    = off_q;
    sram_en    = 1'b0;
    sram_we    = 8'h00;
    dbus_stall = 1'b0;
    dbus_fault = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: if (dbus_ena) begin
        if (dbus_wea != 8'h00) begin
          sram_en = 1'b1;
          sram_we = dbus_wea;
        end else if (rd_ok) begin
          sram_en    = 1'b1;
          dbus_stall = 1'b1;
          cnt_nxt    = 3'(SRAM_LAT - 1);
          off_nxt    = dbus_addr[2:0];
          state_nxt  = WAIT;
        end else begin
          dbus_fault = 1'b1;
        end
      end
      WAIT: begin
        dbus_stall = 1'b1;
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      // The request still on the bus here is the one just served.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dbus_rd_lane #(.LANE(g)) u_lane (
      .word      (sram_rdata),
      .off       (off_q),
      .lane_byte (rd_shift[g])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      off_q   <= 3'd0;
      rdata_q <= 64'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      off_q <= off_nxt;
      if (capture) rdata_q <= rd_shift;
    end
  end
endmodule

// File: tb/tb_dbus_sram_slave.sv
// Scoreboard bench: two responders (SRAM latency 1 and 3), each with its own SRAM
// model, checked against a byte-addressed reference memory.
module tb_dbus_sram_slave;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          dena   [2];
  logic [7:0]    dwea   [2];
  logic [3:0]    drlen  [2];
  logic [63:0]   daddr  [2];
  logic [63:0]   dwdata [2];
  logic [63:0]   drdata [2];
  logic          dstall [2];
  logic          dfault [2];
  logic          sen    [2];
  logic [7:0]    swe    [2];
  logic [AW-1:0] saddr  [2];
  logic [63:0]   swdata [2];
  logic [63:0]   srdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    dbus_sram_slave #(.ADDR_W(AW), .SRAM_LAT(L)) u_dut (
      .clk(clk), .resetn(resetn),
      .dbus_ena(dena[g]), .dbus_wea(dwea[g]), .dbus_rlen(drlen[g]),
      .dbus_addr(daddr[g]), .dbus_wdata(dwdata[g]), .dbus_rdata(drdata[g]),
      .dbus_stall(dstall[g]), .dbus_fault(dfault[g]),
      .sram_en(sen[g]), .sram_we(swe[g]), .sram_addr(saddr[g]),
      .sram_wdata(swdata[g]), .sram_rdata(srdata[g])
    );
    logic [63:0] mem  [1<<AW];
    logic [63:0] pipe [L];
    always @(posedge clk) begin
      if (sen[g]) begin
        if (swe[g] != 8'h00) begin
          for (int b = 0; b < 8; b++)
            if (swe[g][b]) mem[saddr[g]][b*8 +: 8] <= swdata[g][b*8 +: 8];
        end else begin
          pipe[0] <= mem[saddr[g]];
        end
      end
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign srdata[g] = pipe[L-1];
  end

  typedef struct {
    int            dut;
    int            kind;   // 0 write, 1 read, 2 fault
    logic [63:0]   rdata;
    logic [7:0]    we;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  rb [2][1<<(AW+3)];
  logic [63:0] last_rd [2];
  int          n_chk = 0;
  int          n_err = 0;
  int          rls [12] = '{1, 2, 4, 8, 1, 2, 4, 8, 0, 3, 6, 12};

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input int d, input logic [63:0] a);
    logic [63:0] r = 64'h0;
    int base = int'(a[AW+2:3]) * 8;
    int off  = int'(a[2:0]);
    for (int b = 0; b < 8; b++)
      if (off + b < 8) r[b*8 +: 8] = rb[d][base + off + b];
    return r;
  endfunction

  task automatic req(input int d, input logic [7:0] we, input logic [3:0] rl,
                     input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    int   base = int'(a[AW+2:3]) * 8;
    int   off  = int'(a[2:0]);
    int   n    = 0;
    bit   legal;
    dena[d] = 1'b1; dwea[d] = we; drlen[d] = rl; daddr[d] = a; dwdata[d] = wd;
    e.dut = d; e.rdata = last_rd[d]; e.we = we; e.addr = a[AW+2:3]; e.wdata = wd;
    legal = (rl == 1 || rl == 2 || rl == 4 || rl == 8) && (off % int'(rl) == 0);
    if (we != 8'h00) begin
      e.kind = 0;
      sbq.push_back(e);
      for (int b = 0; b < 8; b++) if (we[b]) rb[d][base + b] = wd[b*8 +: 8];
      @(posedge clk); #1;
    end else if (legal) begin
      e.kind = 1;
      e.rdata = ref_read(d, a);
      last_rd[d] = e.rdata;
      sbq.push_back(e);
      do begin @(posedge clk); #1; n++; end while (dstall[d] && n < 20);
      if (dstall[d]) begin
        n_chk++; n_err++;
        $display("FAIL read_timeout: dut %0d stall still 1 after %0d cycles, required 0", d, n);
      end
      // Request stays on the bus through the data cycle, then the master moves on.
      @(posedge clk); #1;
    end else begin
      e.kind = 2;
      sbq.push_back(e);
      @(posedge clk); #1;
    end
    dena[d] = 1'b0;
  endtask

  task automatic pop(input int d, input int kind, output exp_t e, output bit ok);
    n_chk++;
    ok = 1'b0;
    if (sbq.size() == 0 || sbq[0].dut != d || sbq[0].kind != kind) begin
      n_err++;
      $display("FAIL sb_order: dut %0d presented event kind %0d, queue size %0d front kind %0d",
               d, kind, sbq.size(), (sbq.size() != 0) ? sbq[0].kind : -1);
    end else begin
      e  = sbq.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: samples on the falling edge and pops expectations as events appear.
  int scnt [2];
  initial begin
    exp_t e;
    bit   ok;
    scnt[0] = 0; scnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!resetn) begin
          scnt[d] = 0;
        end else begin
          if (dfault[d]) begin
            pop(d, 2, e, ok);
            if (ok) begin
              chk("fault_rdata", drdata[d], e.rdata);
              chk("fault_stall", 64'(dstall[d]), 64'd0);
              chk("fault_sram_en", 64'(sen[d]), 64'd0);
            end
          end else if (dstall[d]) begin
            if (scnt[d] == 0) chk("rd_issue", {55'd0, sen[d], swe[d]}, 64'h100);
            else              chk("wait_sram_en", 64'(sen[d]), 64'd0);
            scnt[d]++;
          end else if (scnt[d] != 0) begin
            pop(d, 1, e, ok);
            if (ok) begin
              chk("rd_data", drdata[d], e.rdata);
              chk("rd_stall_len", 64'(scnt[d]), 64'(lat(d) + 1));
            end
            scnt[d] = 0;
          end
          if (sen[d] && swe[d] != 8'h00) begin
            pop(d, 0, e, ok);
            if (ok) begin
              chk("wr_we", 64'(swe[d]), 64'(e.we));
              chk("wr_addr", 64'(saddr[d]), 64'(e.addr));
              chk("wr_data", swdata[d], e.wdata);
              chk("wr_stall", 64'(dstall[d]), 64'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dena[d] = 1'b0; dwea[d] = 8'h00; drlen[d] = 4'd0; daddr[d] = 64'h0; dwdata[d] = 64'h0;
      last_rd[d] = 64'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", drdata[d], 64'h0);
      chk("rst_stall", 64'(dstall[d]), 64'd0);
      chk("rst_fault", 64'(dfault[d]), 64'd0);
      chk("rst_sram", {55'd0, sen[d], swe[d]}, 64'h0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;

    // Fill the test region (words 8..15) with back-to-back full writes.
    for (int d = 0; d < 2; d++)
      for (int w = 8; w < 16; w++) req(d, 8'hFF, 4'd0, 64'(w * 8), {$urandom, $urandom});

    req(0, 8'hFF, 4'd0, 64'h40, 64'h1122334455667788);
    req(0, 8'h00, 4'd8, 64'h40, 64'h0);
    chk("ld_0x40", drdata[0], 64'h1122334455667788);
    req(0, 8'h00, 4'd1, 64'h43, 64'h0);
    chk("lb_0x43", 64'(drdata[0][7:0]), 64'h55);
    req(0, 8'h00, 4'd2, 64'h46, 64'h0);
    chk("lh_0x46", 64'(drdata[0][15:0]), 64'h1122);
    req(0, 8'hF0, 4'd0, 64'h44, {2{32'hDEADBEEF}});
    req(0, 8'h00, 4'd8, 64'h40, 64'h0);
    chk("sw_ld_0x40", drdata[0], 64'hDEADBEEF55667788);
    req(0, 8'h00, 4'd4, 64'h42, 64'h0);
    req(0, 8'h00, 4'd3, 64'h40, 64'h0);
    chk("fault_keeps", drdata[0], 64'hDEADBEEF55667788);
    req(0, 8'h00, 4'd8, 64'hFFFF_0000_0000_0840, 64'h0);
    chk("wrap_ld", drdata[0], 64'hDEADBEEF55667788);

    req(1, 8'hFF, 4'd0, 64'h48, 64'hA5A5_0102_0304_5A5A);
    req(1, 8'h00, 4'd8, 64'h48, 64'h0);
    chk("lat3_ld", drdata[1], 64'hA5A5_0102_0304_5A5A);

    // Reset while the latency-3 responder is waiting on the SRAM.
    dena[1] = 1'b1; dwea[1] = 8'h00; drlen[1] = 4'd8; daddr[1] = 64'h50;
    begin
      exp_t e;
      e.dut = 1; e.kind = 1; e.rdata = ref_read(1, 64'h50); e.we = 8'h00; e.addr = '0; e.wdata = '0;
      sbq.push_back(e);
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_stall", 64'(dstall[1]), 64'd1);
    resetn = 1'b0; dena[1] = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(dstall[1]), 64'd0);
    chk("mid_rst_sram_en", 64'(sen[1]), 64'd0);
    chk("mid_rst_rdata1", drdata[1], 64'h0);
    chk("mid_rst_rdata0", drdata[0], 64'h0);
    void'(sbq.pop_back());
    @(posedge clk); #1;
    chk("rst_hold_sram_en", 64'(sen[1]), 64'd0);
    resetn = 1'b1;
    last_rd[0] = 64'h0; last_rd[1] = 64'h0;
    @(posedge clk); #1;
    req(1, 8'h00, 4'd8, 64'h48, 64'h0);
    chk("post_rst_ld", drdata[1], 64'hA5A5_0102_0304_5A5A);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 150; k++) begin
        a = {$urandom, $urandom};
        a[AW+2:0] = 11'(64 + $urandom_range(0, 63));
        if ($urandom_range(0, 2) == 0)
          req(d, 8'($urandom_range(1, 255)), 4'($urandom_range(0, 15)), a, {$urandom, $urandom});
        else
          req(d, 8'h00, 4'(rls[$urandom_range(0, 11)]), a, {$urandom, $urandom});
      end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
